// File: rtl/uart_tx_drv.sv
// uart_tx_drv: FIFO-buffered 8N1 UART transmitter driving the uart_tx pad (out_i/oe_i)
module uart_tx_drv #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         div_i,
    input  logic                     enable_i,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     busy_o,
    output logic                     tx_o,
    output logic                     tx_en_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  baud_q, baud_d, div_q, div_d, div_clamp;
    logic              tx_q, tx_d, tx_en_q, tx_en_d;
    logic              push, pop, can_start, bit_end;

    assign ready_o   = level_q != LW'(DEPTH);
    assign level_o   = level_q;
    assign busy_o    = state_q != IDLE;
    assign tx_o      = tx_q;
    assign tx_en_o   = tx_en_q;
    assign push      = valid_i && ready_o;
    assign can_start = enable_i && (level_q != '0);
    assign bit_end   = baud_q == '0;
    assign div_clamp = (div_i == '0) ? DIV_W'(1) : div_i;

    // FIFO storage, pointers and occupancy; a push always lands in memory before any pop can see it
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = data_i;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // Frame sequencer: baud down-counter, bit counter, shift register and serial output
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        div_d     = div_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        if (state_q != IDLE && !bit_end) baud_d = baud_q - DIV_W'(1);
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (can_start) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    baud_d    = div_q;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d    = div_q;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tx_d      = (bit_cnt_q == 3'd7) ? 1'b1 : shift_q[1];
                    state_d   = (bit_cnt_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (bit_end) begin
                    pop     = can_start;
                    state_d = can_start ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            div_d   = div_clamp;
            baud_d  = div_clamp;
            tx_d    = 1'b0;
        end
    end

    // Pad output enable stays asserted until the frame in flight has fully completed
    always_comb begin
        tx_en_d = enable_i | busy_o;
    end

    // State registers; reset discards queued bytes and any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            div_q     <= DIV_W'(1);
            tx_q      <= 1'b1;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            tx_en_q   <= tx_en_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_drv.sv
// tb_uart_tx_drv: directed self-checking bench for uart_tx_drv
module tb_uart_tx_drv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd3;
    logic        enable = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready, busy, tx, tx_en;
    logic [2:0]  level;
    int          errs = 0;
    int          checks = 0;

    uart_tx_drv #(.DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .div_i(div), .enable_i(enable), .data_i(data),
        .valid_i(valid), .ready_o(ready), .level_o(level), .busy_o(busy),
        .tx_o(tx), .tx_en_o(tx_en)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
    endfunction

    task automatic test_reset();
        repeat (3) step();
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        checks++; if (tx_en !== 1'b1) begin errs++; $display("FAIL pre_reset_tx_en: got %b want 1", tx_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (tx_en !== 1'b0) begin errs++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        div = 16'd3;
        enable = 1'b1;
        data = 8'hA5;
        valid = 1'b1;
        step();
        valid = 1'b0;
        checks++; if (level !== 3'd1) begin errs++; $display("FAIL single_level_e0: got %0d want 1", level); end
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL single_tx_e0: got %b want 1", tx); end
        step();
        for (int j = 0; j < 40; j++) begin
            checks++; if (tx !== fbit(8'hA5, j / 4)) begin errs++; $display("FAIL single_tx j=%0d: got %b want %b", j, tx, fbit(8'hA5, j / 4)); end
            checks++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy j=%0d: got %b want 1", j, busy); end
            step();
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_end: got %b want 0", busy); end
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL single_tx_end: got %b want 1", tx); end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL single_level_end: got %0d want 0", level); end
    endtask

    task automatic test_back_to_back();
        int hi = 0;
        div = 16'd1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = 8'(i + 1);
            valid = 1'b1;
            checks++; if (ready !== 1'b1) begin errs++; $display("FAIL b2b_ready push=%0d: got %b want 1", i, ready); end
            step();
        end
        valid = 1'b0;
        for (int j = 3; j < 100; j++) begin
            if (busy === 1'b1) hi++;
            step();
        end
        checks++; if (hi !== 97) begin errs++; $display("FAIL b2b_busy_cycles: got %0d want 97", hi); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL b2b_level_end: got %0d want 0", level); end
    endtask

    task automatic test_full();
        div = 16'd1;
        enable = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            data = 8'(i + 1);
            valid = 1'b1;
            step();
            if (i == 3) begin
                checks++; if (level !== 3'd4) begin errs++; $display("FAIL full_level: got %0d want 4", level); end
                checks++; if (ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %b want 0", ready); end
            end
        end
        valid = 1'b0;
        checks++; if (level !== 3'd4) begin errs++; $display("FAIL full_drop_level: got %0d want 4", level); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL full_busy: got %b want 0", busy); end
        checks++; if (tx_en !== 1'b0) begin errs++; $display("FAIL full_tx_en: got %b want 0", tx_en); end
        enable = 1'b1;
        step();
        for (int j = 0; j < 80; j++) begin
            checks++; if (tx !== fbit(8'(j / 20 + 1), (j % 20) / 2)) begin errs++; $display("FAIL full_tx j=%0d: got %b want %b", j, tx, fbit(8'(j / 20 + 1), (j % 20) / 2)); end
            step();
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL full_busy_end: got %b want 0", busy); end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL full_level_end: got %0d want 0", level); end
        repeat (20) step();
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errs++; $display("FAIL full_no_fifth: got busy=%b tx=%b want busy=0 tx=1", busy, tx); end
    endtask

    task automatic test_enable_drop();
        div = 16'd3;
        enable = 1'b1;
        data = 8'h3C;
        valid = 1'b1;
        step();
        data = 8'hC3;
        step();
        valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            checks++; if (tx !== fbit(8'h3C, j / 4)) begin errs++; $display("FAIL drop_tx j=%0d: got %b want %b", j, tx, fbit(8'h3C, j / 4)); end
            checks++; if (tx_en !== 1'b1) begin errs++; $display("FAIL drop_tx_en j=%0d: got %b want 1", j, tx_en); end
            if (j == 10) enable = 1'b0;
            step();
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL drop_busy: got %b want 0", busy); end
        checks++; if (tx_en !== 1'b1) begin errs++; $display("FAIL drop_tx_en_idle: got %b want 1", tx_en); end
        step();
        checks++; if (tx_en !== 1'b0) begin errs++; $display("FAIL drop_tx_en_off: got %b want 0", tx_en); end
        checks++; if (level !== 3'd1) begin errs++; $display("FAIL drop_level: got %0d want 1", level); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL drop_idle: got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_div_change();
        logic e;
        div = 16'd3;
        enable = 1'b1;
        data = 8'h96;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int j = 0; j < 120; j++) begin
            e = (j < 40) ? fbit(8'hC3, j / 4) : fbit(8'h96, (j - 40) / 8);
            checks++; if (tx !== e) begin errs++; $display("FAIL div_tx j=%0d: got %b want %b", j, tx, e); end
            if (j == 12) div = 16'd7;
            step();
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL div_busy_end: got %b want 0", busy); end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL div_level_end: got %0d want 0", level); end
        div = 16'd0;
        data = 8'hF0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        for (int j = 0; j < 20; j++) begin
            checks++; if (tx !== fbit(8'hF0, j / 2)) begin errs++; $display("FAIL div0_tx j=%0d: got %b want %b", j, tx, fbit(8'hF0, j / 2)); end
            step();
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL div0_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        div = 16'd1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 8'h11 * 8'(i + 1);
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        repeat (17) step();
        checks++; if (busy !== 1'b1 || tx !== 1'b1 || level !== 3'd2) begin errs++; $display("FAIL rmf_pre: got busy=%b tx=%b level=%0d want 1 1 2", busy, tx, level); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errs++; $display("FAIL rmf_tx: got %b want 1", tx); end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL rmf_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rmf_busy: got %b want 0", busy); end
        checks++; if (tx_en !== 1'b0) begin errs++; $display("FAIL rmf_tx_en: got %b want 0", tx_en); end
        checks++; if (ready !== 1'b1) begin errs++; $display("FAIL rmf_ready: got %b want 1", ready); end
        step();
        rst = 1'b0;
        for (int j = 0; j < 40; j++) begin
            checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL rmf_quiet j=%0d: got tx=%b busy=%b want tx=1 busy=0", j, tx, busy); end
            step();
        end
        checks++; if (level !== 3'd0) begin errs++; $display("FAIL rmf_level_end: got %0d want 0", level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_enable_drop();
        test_div_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
